// File: rtl/ram_dumper_pkg.sv
// rtl/ram_dumper_pkg.sv - shared state encoding and frame constants for ram_dumper
package ram_dumper_pkg;

  // Command frame walk, then the read/send loop, then the trailing checksum byte
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_AH   = 4'd1,
    S_GET_AL   = 4'd2,
    S_GET_LH   = 4'd3,
    S_GET_LL   = 4'd4,
    S_RD_ADDR  = 4'd5,
    S_RD_WAIT  = 4'd6,
    S_SEND     = 4'd7,
    S_WAIT_TX  = 4'd8,
    S_SEND_SUM = 4'd9,
    S_WAIT_SUM = 4'd10
  } state_t;

  localparam logic [7:0] CMD_BYTE_DEF = 8'h44;
  localparam int         HDR_BYTES    = 5;

endpackage

// File: rtl/ram_dumper.sv
// rtl/ram_dumper.sv - UART-driven RAM readback engine with trailing additive checksum
module ram_dumper
  import ram_dumper_pkg::*;
#(
  parameter int         ADDR_W   = 16,
  parameter logic [7:0] CMD_BYTE = CMD_BYTE_DEF,
  parameter int         TIMEOUT  = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [7:0]        tx_data,
  output logic              transmit,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              ram_sel,
  output logic              busy
);

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_hi;
  logic [7:0]        r_tx_data;
  logic [7:0]        r_sum;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_len;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_in_hdr;
  logic              w_timeout;
  logic [15:0]       w_len_rx;

  // High header byte was parked in r_hi; the low byte is still on rx_data
  assign w_len_rx  = {r_hi, rx_data};
  assign w_in_hdr  = (r_state == S_GET_AH) || (r_state == S_GET_AL) ||
                     (r_state == S_GET_LH) || (r_state == S_GET_LL);
  assign w_timeout = (TIMEOUT != 0) && (r_to_cnt == TO_W'(TIMEOUT));
  assign tx_data   = r_tx_data;
  assign ram_addr  = r_addr;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; a header byte wins over a timeout landing in the same cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (rx_done && (rx_data == CMD_BYTE)) w_next = S_GET_AH;
      S_GET_AH:   if (rx_done) w_next = S_GET_AL; else if (w_timeout) w_next = S_IDLE;
      S_GET_AL:   if (rx_done) w_next = S_GET_LH; else if (w_timeout) w_next = S_IDLE;
      S_GET_LH:   if (rx_done) w_next = S_GET_LL; else if (w_timeout) w_next = S_IDLE;
      S_GET_LL: begin
        if (rx_done)        w_next = (w_len_rx == 16'd0) ? S_SEND_SUM : S_RD_ADDR;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_RD_ADDR:  w_next = S_RD_WAIT;
      S_RD_WAIT:  w_next = S_SEND;
      S_SEND:     w_next = S_WAIT_TX;
      S_WAIT_TX:  if (tx_done) w_next = (r_len == 16'd0) ? S_SEND_SUM : S_RD_ADDR;
      S_SEND_SUM: w_next = S_WAIT_SUM;
      S_WAIT_SUM: if (tx_done) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    transmit = (r_state == S_SEND) || (r_state == S_SEND_SUM);
    ram_sel  = (r_state == S_RD_ADDR) || (r_state == S_RD_WAIT) ||
               (r_state == S_SEND) || (r_state == S_WAIT_TX);
    busy     = (r_state != S_IDLE);
  end

  // Datapath: header capture, and byte/checksum/address/length update as SEND is entered
  // so tx_data is already valid during the transmit pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi      <= 8'h00;
      r_tx_data <= 8'h00;
      r_sum     <= 8'h00;
      r_addr    <= '0;
      r_len     <= 16'd0;
    end else begin
      case (r_state)
        S_GET_AH: if (rx_done) r_hi <= rx_data;
        S_GET_AL: if (rx_done) r_addr <= ADDR_W'({r_hi, rx_data});
        S_GET_LH: if (rx_done) r_hi <= rx_data;
        S_GET_LL: begin
          if (rx_done) begin
            r_len <= w_len_rx;
            r_sum <= 8'h00;
            if (w_len_rx == 16'd0) r_tx_data <= 8'h00;
          end
        end
        S_RD_WAIT: begin
          r_tx_data <= ram_data;
          r_sum     <= r_sum + ram_data;
          r_addr    <= r_addr + ADDR_W'(1);
          r_len     <= r_len - 16'd1;
        end
        S_WAIT_TX: if (tx_done && (r_len == 16'd0)) r_tx_data <= r_sum;
        default: ;
      endcase
    end
  end

  // Inter-byte timeout: counts idle cycles while collecting the header
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_to_cnt <= '0;
    else if (w_in_hdr && !rx_done && !w_timeout) r_to_cnt <= r_to_cnt + TO_W'(1);
    else                                        r_to_cnt <= '0;
  end

endmodule

// File: tb/tb_ram_dumper.sv
// tb/tb_ram_dumper.sv - self-checking bench for ram_dumper against a byte-stream reference model
module tb_ram_dumper;
  import ram_dumper_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        transmit;
  logic        tx_done;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_sel;
  logic        busy;

  logic [7:0]  mem [0:65535];
  logic [7:0]  cap_q [$];
  int          total = 0;
  int          bad = 0;
  int          extra_tx = 0;
  int          unstable = 0;
  int          sel_cycles = 0;
  int          tx_delay = 2;

  ram_dumper #(.ADDR_W(16), .CMD_BYTE(8'h44), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .transmit(transmit), .tx_done(tx_done),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_sel(ram_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data valid one clock after the address
  always @(posedge clk) ram_data <= mem[ram_addr];

  always @(negedge clk) if (ram_sel) sel_cycles++;

  // UART model: capture each transmitted byte, hold off tx_done for tx_delay cycles
  initial begin : uart
    logic [7:0] held;
    int n;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst === 1'b1 && transmit === 1'b1) begin
        cap_q.push_back(tx_data);
        held = tx_data;
        n = 0;
        while (n < tx_delay && rst === 1'b1) begin
          @(negedge clk);
          n++;
          if (rst === 1'b1) begin
            if (transmit !== 1'b0) extra_tx++;
            if (tx_data !== held) unstable++;
          end
        end
        if (rst === 1'b1) tx_done = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] addr, input logic [15:0] len);
    logic [7:0] hdr [HDR_BYTES];
    hdr[0] = 8'h44; hdr[1] = addr[15:8]; hdr[2] = addr[7:0];
    hdr[3] = len[15:8]; hdr[4] = len[7:0];
    for (int i = 0; i < HDR_BYTES; i++) send_byte(hdr[i]);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  // Reference: len bytes from addr upward (wrapping at 64K) then their sum mod 256
  task automatic expect_dump(input int addr, input int len, input int base, input string tag);
    int sum = 0;
    logic [7:0] b;
    check({tag, "_count"}, cap_q.size() - base, len + 1);
    for (int i = 0; i < len; i++) begin
      b = mem[(addr + i) % 65536];
      sum = (sum + b) % 256;
      check($sformatf("%s_byte%0d", tag, i), cap_q[base + i], b);
    end
    check({tag, "_sum"}, cap_q[base + len], sum);
  endtask

  initial begin : main
    int base, e0, u0, s0, n, a, l;
    rst = 1'b0; rx_data = 8'h00; rx_done = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    @(negedge clk); @(negedge clk);
    check("rst_tx_data", tx_data, 0);
    check("rst_transmit", transmit, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_sel", ram_sel, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;

    // 1: basic dump plus first-byte latency
    mem[16'h0010] = 8'h01; mem[16'h0011] = 8'h02; mem[16'h0012] = 8'h03; mem[16'h0013] = 8'h04;
    base = cap_q.size();
    send_byte(8'h44); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    @(negedge clk); rx_data = 8'h04; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
    @(negedge clk); check("t1_lat_early", transmit, 0);
    @(negedge clk); check("t1_lat_pulse", transmit, 1);
    check("t1_first_data", tx_data, 8'h01);
    wait_idle(200, "t1_idle");
    expect_dump(16'h0010, 4, base, "t1");
    check("t1_sum_const", cap_q[base + 4], 8'h0A);

    // 2: zero length emits only the checksum, RAM never claimed
    s0 = sel_cycles; base = cap_q.size();
    send_frame(16'h1234, 16'd0);
    wait_idle(100, "t2_idle");
    expect_dump(16'h1234, 0, base, "t2");
    check("t2_no_sel", sel_cycles - s0, 0);

    // 3: address wrap
    mem[16'hFFFF] = 8'hAA; mem[16'h0000] = 8'h55;
    base = cap_q.size();
    send_frame(16'hFFFF, 16'd2);
    wait_idle(200, "t3_idle");
    expect_dump(16'hFFFF, 2, base, "t3");
    check("t3_sum_const", cap_q[base + 2], 8'hFF);

    // 4: header timeout then a valid frame
    base = cap_q.size();
    send_byte(8'h44); send_byte(8'h00);
    repeat (50) @(negedge clk);
    check("t4_still_busy", busy, 1);
    repeat (70) @(negedge clk);
    check("t4_timed_out", busy, 0);
    check("t4_no_tx", cap_q.size() - base, 0);
    base = cap_q.size();
    send_frame(16'h0500, 16'd5);
    wait_idle(300, "t4_idle");
    expect_dump(16'h0500, 5, base, "t4");

    // 5: stray rx during dump and a long tx_done stall
    tx_delay = 1000; base = cap_q.size(); e0 = extra_tx; u0 = unstable;
    send_frame(16'h0200, 16'd3);
    n = 0;
    while (cap_q.size() <= base && n < 50) begin @(negedge clk); n++; end
    send_byte(8'h44); send_byte(8'h00); send_byte(8'h44);
    wait_idle(5000, "t5_idle");
    expect_dump(16'h0200, 3, base, "t5");
    check("t5_no_extra_tx", extra_tx - e0, 0);
    check("t5_tx_stable", unstable - u0, 0);

    // 6: reset mid-dump, stray idle byte ignored
    tx_delay = 5; base = cap_q.size();
    send_frame(16'h3000, 16'd8);
    n = 0;
    while (cap_q.size() < base + 2 && n < 300) begin @(negedge clk); n++; end
    check("t6_two_bytes", cap_q.size() - base, 2);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_transmit", transmit, 0);
    check("t6_rst_tx_data", tx_data, 0);
    check("t6_rst_ram_addr", ram_addr, 0);
    check("t6_rst_ram_sel", ram_sel, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_byte0", cap_q[base], mem[16'h3000]);
    check("t6_byte1", cap_q[base + 1], mem[16'h3001]);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    base = cap_q.size();
    send_byte(8'h41);
    repeat (5) @(negedge clk);
    check("t6_stray_idle", busy, 0);
    check("t6_stray_no_tx", cap_q.size() - base, 0);

    // Randomized frames against the reference model
    for (int k = 0; k < 6; k++) begin
      a = (k == 0) ? 16'hFFFA : int'($urandom_range(0, 65535));
      l = (k == 0) ? 10 : int'($urandom_range(1, 12));
      tx_delay = int'($urandom_range(1, 6));
      base = cap_q.size();
      send_frame(16'(a), 16'(l));
      wait_idle(400, $sformatf("rnd%0d_idle", k));
      expect_dump(a, l, base, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
